// File: rtl/cla_pkg.sv
// Shared defaults and helpers for the pipelined carry-lookahead adder/subtractor.
//   CLA_WIDTH  default operand/result width
//   CLA_GROUP  default bits per lookahead group (one pipeline stage per group)
//   cla_nstg() number of pipeline stages (= latency in cycles) for a width/group pair
package cla_pkg;

   localparam int unsigned CLA_WIDTH = 16;
   localparam int unsigned CLA_GROUP = 4;

   function automatic int unsigned cla_nstg(int unsigned width, int unsigned group);
      return width / group;
   endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead group.
//   a, b        group operand bits
//   c_in        carry into bit 0 of the group
//   s           group sum bits
//   c_out       carry out of the group's top bit
//   c_into_msb  carry into the group's top bit (used for signed overflow)
module cla_group #(
   parameter int unsigned GROUP = 4
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   input  logic             c_in,
   output logic [GROUP-1:0] s,
   output logic             c_out,
   output logic             c_into_msb
);

   logic [GROUP-1:0] g;
   logic [GROUP-1:0] p;
   logic [GROUP:0]   c;
   logic             term;

   assign g = a & b;
   assign p = a ^ b;

   // Every carry is a flat sum of products of g, p and c_in:
   //   c[i] = c_in&p[0]&..&p[i-1] | OR_j ( g[j]&p[j+1]&..&p[i-1] )
   // so no carry depends on a lower carry inside the group.
   always_comb begin
      c    = '0;
      term = 1'b0;
      c[0] = c_in;
      for (int i = 1; i <= GROUP; i++) begin
         term = c_in;
         for (int j = 0; j < i; j++) begin
            term = term & p[j];
         end
         c[i] = term;
         for (int j = 0; j < i; j++) begin
            term = g[j];
            for (int m = j + 1; m < i; m++) begin
               term = term & p[m];
            end
            c[i] = c[i] | term;
         end
      end
   end

   assign s          = p ^ c[GROUP-1:0];
   assign c_out      = c[GROUP];
   assign c_into_msb = c[GROUP-1];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor, one GROUP-bit group resolved per stage.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready = pipe may advance)
//   a, b, cin, op_sub    operands; op_sub=1 computes a-b and ignores cin
//   out_valid/out_ready  result handshake
//   s, cout, ovf, zero   result, carry out (no-borrow in sub), signed overflow, result==0
// Latency is WIDTH/GROUP cycles; the whole pipe shifts together or holds together.
module pipelined_cla_addsub
   import cla_pkg::*;
#(
   parameter int unsigned WIDTH = CLA_WIDTH,
   parameter int unsigned GROUP = CLA_GROUP
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             op_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   if (GROUP == 0 || (WIDTH % GROUP) != 0) begin : gen_bad_cfg
      $error("pipelined_cla_addsub: WIDTH must be a non-zero multiple of GROUP");
   end

   localparam int unsigned NSTG = cla_nstg(WIDTH, GROUP);

   // a_rem/b_rem are shifted down each stage so the next group is always in the low bits.
   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] sum;
      logic [WIDTH-1:0] a_rem;
      logic [WIDTH-1:0] b_rem;
      logic             carry;
      logic             c_msb_in;
   } stage_t;

   stage_t           stg_in [NSTG];
   stage_t           stg_d  [NSTG];
   stage_t           stg_q  [NSTG];
   logic [GROUP-1:0] grp_s  [NSTG];
   logic             grp_co [NSTG];
   logic             grp_cm [NSTG];
   logic             adv;

   assign adv      = !stg_q[NSTG-1].valid || out_ready;
   assign in_ready = adv;

   // Stage inputs: stage 0 takes conditioned operands, later stages take the previous register.
   always_comb begin
      for (int k = 0; k < NSTG; k++) begin
         stg_in[k] = '0;
      end
      stg_in[0].valid = in_valid;
      stg_in[0].a_rem = a;
      stg_in[0].b_rem = op_sub ? ~b : b;
      stg_in[0].carry = op_sub ? 1'b1 : cin;
      for (int k = 1; k < NSTG; k++) begin
         stg_in[k] = stg_q[k-1];
      end
   end

   for (genvar k = 0; k < NSTG; k++) begin : gen_stage
      cla_group #(
         .GROUP(GROUP)
      ) u_grp (
         .a          (stg_in[k].a_rem[GROUP-1:0]),
         .b          (stg_in[k].b_rem[GROUP-1:0]),
         .c_in       (stg_in[k].carry),
         .s          (grp_s[k]),
         .c_out      (grp_co[k]),
         .c_into_msb (grp_cm[k])
      );
   end

   always_comb begin
      for (int k = 0; k < NSTG; k++) begin
         stg_d[k]                         = stg_in[k];
         stg_d[k].sum[k*GROUP +: GROUP]   = grp_s[k];
         stg_d[k].a_rem                   = stg_in[k].a_rem >> GROUP;
         stg_d[k].b_rem                   = stg_in[k].b_rem >> GROUP;
         stg_d[k].carry                   = grp_co[k];
         if (k == NSTG - 1) begin
            stg_d[k].c_msb_in = grp_cm[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NSTG; k++) begin
            stg_q[k] <= '0;
         end
      end else if (adv) begin
         for (int k = 0; k < NSTG; k++) begin
            stg_q[k] <= stg_d[k];
         end
      end
   end

   // Flags come straight off the last register; zero is qualified by valid so it reads 0 in reset.
   always_comb begin
      out_valid = stg_q[NSTG-1].valid;
      s         = stg_q[NSTG-1].sum;
      cout      = stg_q[NSTG-1].carry;
      ovf       = stg_q[NSTG-1].c_msb_in ^ stg_q[NSTG-1].carry;
      zero      = stg_q[NSTG-1].valid & ~|stg_q[NSTG-1].sum;
   end

   // Fully consumed operand bits and the non-final into-MSB carries are intentionally dropped.
   logic unused_bits;
   always_comb begin
      unused_bits = ^{stg_q[NSTG-1].a_rem, stg_q[NSTG-1].b_rem};
      for (int k = 0; k < NSTG - 1; k++) begin
         unused_bits = unused_bits ^ grp_cm[k];
      end
   end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
module tb_pipelined_cla_addsub;

   localparam int W    = 16;
   localparam int NSTG = 4;

   logic         clk = 1'b0;
   logic         rst_n, in_valid, in_ready, cin, op_sub;
   logic         out_valid, out_ready, cout, ovf, zero;
   logic [W-1:0] a, b, s;

   typedef struct packed {
      logic [W-1:0] s;
      logic         cout;
      logic         ovf;
      logic         zero;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   logic hist [128];
   bit   use_dir  = 1'b0;
   exp_t dir_exp;
   int   rdy_mode = 0;
   int   tog      = 0;

   pipelined_cla_addsub #(
      .WIDTH(W),
      .GROUP(4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .op_sub    (op_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Reference: plain integer arithmetic on the operand values.
   function automatic exp_t model(logic [W-1:0] ma, logic [W-1:0] mb, logic mc, logic ms);
      exp_t e;
      int   ua, ub, sa, sb, r, sr;
      ua = int'(ma);
      ub = int'(mb);
      sa = int'($signed(ma));
      sb = int'($signed(mb));
      if (!ms) begin
         r      = ua + ub + int'(mc);
         sr     = sa + sb + int'(mc);
         e.cout = (r > 65535);
      end else begin
         r      = ua - ub;
         sr     = sa - sb;
         e.cout = (ua >= ub);
      end
      e.s    = r[W-1:0];
      e.ovf  = (sr > 32767) || (sr < -32768);
      e.zero = (e.s == '0);
      return e;
   endfunction

   function automatic exp_t mk(logic [W-1:0] ms, logic c, logic o, logic z);
      exp_t e;
      e.s    = ms;
      e.cout = c;
      e.ovf  = o;
      e.zero = z;
      return e;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // out_ready generator: 0 always ready, 1 pattern 1,0,0, 2 random, 3 never ready
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       begin out_ready = (tog % 3 == 0); tog++; end
         2:       out_ready = ($urandom_range(0, 2) != 0);
         default: out_ready = 1'b0;
      endcase
   end

   // Monitor/scoreboard: compare the head of the queue whenever a result is presented,
   // pop it on consume, and enqueue the expectation of every accepted beat.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         hist[cyc % 128] = out_valid;
         chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output: got s=%h with no beat outstanding", s);
            end else begin
               chk("result", 64'({s, cout, ovf, zero}), 64'(exp_q[0]));
               if (out_ready) void'(exp_q.pop_front());
            end
         end
         if (in_valid && in_ready) exp_q.push_back(use_dir ? dir_exp : model(a, b, cin, op_sub));
      end
   end

   task automatic send(logic [W-1:0] ta, logic [W-1:0] tb_, logic tc, logic ts);
      bit acc;
      int n;
      a = ta; b = tb_; cin = tc; op_sub = ts; in_valid = 1'b1;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready;
         n++;
      end
      if (!acc) chk("accept_timeout", 64'(0), 64'(1));
      @(posedge clk);
      #1;
      use_dir = 1'b0;
   endtask

   task automatic send_dir(logic [W-1:0] ta, logic [W-1:0] tb_, logic tc, logic ts, exp_t e);
      dir_exp = e;
      use_dir = 1'b1;
      send(ta, tb_, tc, ts);
   endtask

   task automatic idle(int n);
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int n;
      in_valid = 1'b0;
      rdy_mode = 0;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_empty", 64'(exp_q.size()), 64'(0));
   endtask

   function automatic logic [W-1:0] pick();
      logic [W-1:0] corner [4];
      corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h7FFF; corner[3] = 16'h8000;
      if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
      return W'($urandom);
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   c0;
      logic pat [4];
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op_sub = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_s",         64'(s),         64'(0));
      chk("rst_cout",      64'(cout),      64'(0));
      chk("rst_ovf",       64'(ovf),       64'(0));
      chk("rst_zero",      64'(zero),      64'(0));
      chk("rst_in_ready",  64'(in_ready),  64'(1));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: full carry chain and latency
      c0 = cyc;
      send_dir(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1));
      idle(6);
      chk("lat1_pre",  64'(hist[(c0 + NSTG - 1) % 128]), 64'(0));
      chk("lat1_at",   64'(hist[(c0 + NSTG) % 128]),     64'(1));

      // 2: signed overflow, then a small subtract with borrow
      send_dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1, 1'b0));
      send_dir(16'h0003, 16'h0005, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0, 1'b0));
      drain();

      // 3: cin used in add, ignored in sub
      send_dir(16'h1234, 16'h1234, 1'b1, 1'b0, mk(16'h2469, 1'b0, 1'b0, 1'b0));
      send_dir(16'h1234, 16'h1234, 1'b1, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b1));
      drain();

      // 4: back-pressure with out_ready 1,0,0 repeating
      tog      = 0;
      rdy_mode = 1;
      for (int i = 0; i < 8; i++) begin
         send_dir(W'(i), W'(i), 1'b0, 1'b0, mk(W'(2 * i), 1'b0, 1'b0, i == 0));
      end
      drain();

      // 5: bubbles propagate as empty slots at full rate
      @(posedge clk);
      #1;
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;
      c0 = cyc;
      send(W'($urandom), W'($urandom), 1'b0, 1'b0);
      idle(1);
      send(W'($urandom), W'($urandom), 1'b1, 1'b0);
      send(W'($urandom), W'($urandom), 1'b0, 1'b1);
      idle(6);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("bubble_slot%0d", i), 64'(hist[(c0 + NSTG + i) % 128]), 64'(pat[i]));
      end
      drain();

      // 6: asynchronous reset with beats in flight and the head stalled
      rdy_mode = 3;
      send(16'h1111, 16'h2222, 1'b0, 1'b0);
      send(16'h3333, 16'h0101, 1'b1, 1'b0);
      send(16'h5555, 16'h0505, 1'b0, 1'b1);
      idle(2);
      chk("pre_rst_stalled", 64'(out_valid), 64'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
      chk("mid_rst_s",         64'(s),         64'(0));
      chk("mid_rst_zero",      64'(zero),      64'(0));
      chk("mid_rst_in_ready",  64'(in_ready),  64'(1));
      exp_q.delete();
      @(negedge clk);
      #2;
      rst_n    = 1'b1;
      rdy_mode = 0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      c0 = cyc;
      send_dir(16'h00FF, 16'h0F01, 1'b0, 1'b0, mk(16'h1000, 1'b0, 1'b0, 1'b0));
      idle(6);
      chk("lat6_pre", 64'(hist[(c0 + NSTG - 1) % 128]), 64'(0));
      chk("lat6_at",  64'(hist[(c0 + NSTG) % 128]),     64'(1));
      drain();

      // Random traffic with random bubbles and stalls
      rdy_mode = 2;
      repeat (400) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         else send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
